uart_tx: RTL and testbench

- 8-bit asynchronous serial transmitter; the transmit-side counterpart of the team's UART receiver.
- Accepts bytes on a valid/ready stream interface and serialises them onto o_tx as 8N1/8E1/8O1/8N2-style frames.
- Bit timing is derived from a free-running divider off i_clk.
- Sits between internal byte producers and the top-level TX pin.

---
 rtl/uart_tx.sv | 68 ++++++
 tb/tb_uart_tx.sv | 71 +++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8-bit serial transmitter with a valid/ready byte input and configurable parity and stop bits.
module uart_tx #(
  parameter int F = 50000000,
  parameter int BAUD = 115200,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic       o_busy,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_tx
);
  localparam int MOD = (F + BAUD / 2) / BAUD;
  localparam int CW = $clog2(MOD);
  if (MOD < 2 || PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad
    $error("uart_tx: illegal parameters");
  end
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t state, nstate;
  logic [CW-1:0] cnt;
  logic [2:0] idx, idx_n;
  logic [7:0] sh;
  logic par, stop_cnt, tick, last, acc, tx_d;
  assign tick = cnt == CW'(MOD - 1);
  assign last = STOP_BITS == 1 || stop_cnt;
  assign o_ready = !i_rst && (state == IDLE || (state == STOP && tick && last));
  assign acc = i_valid && o_ready;
  assign o_busy = state != IDLE;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state <= IDLE;
      o_tx <= 1'b1;
      cnt <= '0;
      idx <= '0;
      stop_cnt <= 1'b0;
    end else begin
      state <= nstate;
      o_tx <= tx_d;
      cnt <= acc || tick ? '0 : cnt + 1'b1;
      idx <= acc ? '0 : idx_n;
      stop_cnt <= acc ? 1'b0 : stop_cnt ^ (state == STOP && tick);
    end
  // Byte and its parity are captured once at accept, so later input changes cannot disturb the frame.
  always_ff @(posedge i_clk)
    if (acc) begin
      sh <= i_data;
      par <= ^i_data ^ (PARITY == 1);
    end
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    nstate = acc ? START : IDLE;
      START:   nstate = tick ? DATA : START;
      DATA:    nstate = tick && idx == 3'd7 ? (PARITY != 0 ? PAR : STOP) : DATA;
      PAR:     nstate = tick ? STOP : PAR;
      STOP:    nstate = tick && last ? (acc ? START : IDLE) : STOP;
      default: nstate = IDLE;
    endcase
  end
  // The line value is computed from the next state so o_tx can be a plain register.
  always_comb begin
    idx_n = state == DATA && tick ? 3'(idx + 3'd1) : idx;
    tx_d = nstate == START ? 1'b0 : nstate == DATA ? sh[idx_n] : nstate == PAR ? par : 1'b1;
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized checking of uart_tx against a per-cycle expected line waveform for several configurations.
module tb_uart_tx;
  localparam int N = 5;
  localparam int NCYC = 12000;
  localparam int FA [N] = '{1000000, 1000000, 1000000, 1000000, 50000000};
  localparam int BA [N] = '{100000, 100000, 100000, 100000, 115200};
  localparam int PA [N] = '{0, 2, 1, 0, 1};
  localparam int SA [N] = '{1, 1, 1, 2, 2};
  localparam int MA [N] = '{10, 10, 10, 10, 434};
  logic clk = 1'b0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  for (genvar g = 0; g < N; g++) begin : g_dut
    logic rst = 1'b1;
    logic valid = 1'b0;
    logic [7:0] data = 8'h00;
    logic busy, ready, tx;
    bit q[$];
    uart_tx #(.F(FA[g]), .BAUD(BA[g]), .PARITY(PA[g]), .STOP_BITS(SA[g])) dut (
      .i_clk(clk), .i_rst(rst), .o_busy(busy), .i_data(data),
      .i_valid(valid), .o_ready(ready), .o_tx(tx));
    initial begin
      byte unsigned dir [7] = '{8'hA5, 8'h01, 8'h00, 8'hFF, 8'h3C, 8'h55, 8'h12};
      int nd = 0;
      int ones;
      bit acc = 1'b1;
      bit bits[$];
      for (int c = 0; c < NCYC; c++) begin
        @(negedge clk);
        check($sformatf("u%0d.tx@%0d", g, c), int'(tx), q.size() != 0 ? int'(q[0]) : 1);
        check($sformatf("u%0d.busy@%0d", g, c), int'(busy), int'(q.size() != 0));
        check($sformatf("u%0d.ready@%0d", g, c), int'(ready), int'(!rst && q.size() <= 1));
        rst = c < 2 || c == 555 || $urandom_range(0, 2999) == 0;
        if (acc || !valid) begin
          valid = nd < 7 || $urandom_range(0, 3) != 0;
          data = nd < 7 ? dir[nd] : 8'($urandom);
          nd++;
        end
        acc = valid && !rst && q.size() <= 1;
        if (q.size() != 0) void'(q.pop_front());
        if (rst) q.delete();
        if (acc) begin
          ones = 0;
          bits.delete();
          bits.push_back(1'b0);
          for (int i = 0; i < 8; i++) begin
            ones += int'(data[i]);
            bits.push_back(data[i]);
          end
          if (PA[g] == 2) bits.push_back(ones % 2 == 1);
          if (PA[g] == 1) bits.push_back(ones % 2 == 0);
          repeat (SA[g]) bits.push_back(1'b1);
          foreach (bits[i]) repeat (MA[g]) q.push_back(bits[i]);
        end
      end
    end
  end
  initial begin
    repeat (NCYC + 3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
